// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and widths.
//   ADDR_W        : PC / instruction address width
//   INSTR_W       : instruction word width
//   addr_t        : PC-sized address
//   instr_t       : instruction word
//   fetch_entry_t : one fetch buffer slot, {instr, pc}
package cpu_pkg;
  localparam int ADDR_W  = 11;
  localparam int INSTR_W = 16;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [INSTR_W-1:0] instr_t;

  typedef struct packed {
    instr_t instr;
    addr_t  pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Small circular fetch buffer with a synchronous clear.
//   clk, rst : clock, async active-high reset
//   clear    : drop all entries (wins over push/pop)
//   push     : write wdata at the tail
//   pop      : retire the head
//   count    : occupied entries, 0..DEPTH
//   head     : entry at the read pointer (registered storage, no bypass)
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = fetch_entry_t
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  T                           wdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output T                           head
);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PTR_W = $clog2(DEPTH);

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clear) begin
      // Realign rather than zero so storage stays untouched.
      rd_ptr_q <= wr_ptr_q;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // The upstream credit scheme makes these unreachable; hitting one is a bug.
  always @(posedge clk) begin
    if (!rst && !clear) begin
      assert (!(push && count_q == CNT_W'(DEPTH)))
        else $error("fetch_fifo: push into full buffer");
      assert (!(pop && count_q == '0))
        else $error("fetch_fifo: pop from empty buffer");
    end
  end
endmodule

// File: rtl/instr_fetch.sv
// Fetch stage between the PC counter and the decoder.
//   clk, reset  : clock, async active-high reset
//   pc          : current PC
//   next_instr  : advance request to the PC counter (same as imem_en)
//   flush       : jump being applied; kills buffered and in-flight fetches
//   imem_en     : memory read enable
//   imem_addr   : memory read address (= pc)
//   imem_rdata  : read data, one cycle after imem_en
//   instr       : head instruction
//   instr_pc    : head instruction address
//   instr_valid : head valid
//   instr_ready : decoder accepts head
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = cpu_pkg::ADDR_W,
  parameter int INSTR_W = cpu_pkg::INSTR_W,
  parameter int DEPTH   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc,
  output logic               next_instr,
  input  logic               flush,
  output logic               imem_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready
);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int CW1   = CNT_W + 1;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } entry_t;

  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_addr_q, inflight_addr_d;
  logic [CNT_W-1:0]  fifo_count;
  entry_t            head, wdata;
  logic              pop, push, issue;
  logic [CW1-1:0]    credit_used, credit_lim;

  assign pop = instr_valid & instr_ready;

  // count + inflight - pop < DEPTH, rearranged to avoid underflow.
  assign credit_used = CW1'(fifo_count) + CW1'(inflight_q);
  assign credit_lim  = CW1'(DEPTH) + CW1'(pop);
  assign issue       = !reset && !flush && (credit_used < credit_lim);

  assign imem_en    = issue;
  assign next_instr = issue;
  assign imem_addr  = pc;

  // Data returning in a flush cycle belongs to the killed path.
  assign push        = inflight_q & !flush;
  assign wdata.instr = imem_rdata;
  assign wdata.pc    = inflight_addr_q;

  always_comb begin
    inflight_d      = issue;
    inflight_addr_d = issue ? pc : inflight_addr_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
    end else begin
      inflight_q      <= inflight_d;
      inflight_addr_q <= inflight_addr_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH), .T(entry_t)) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .clear (flush),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .count (fifo_count),
    .head  (head)
  );

  assign instr_valid = (fifo_count != '0) && !flush;
  assign instr       = head.instr;
  assign instr_pc    = head.pc;
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a PC counter and memory model.
module tb_instr_fetch;
  logic        clk, reset, flush, instr_ready;
  logic [10:0] pc, tgt;
  logic        next_instr, imem_en, instr_valid;
  logic [10:0] imem_addr, instr_pc;
  logic [15:0] imem_rdata, instr;

  int checks = 0;
  int errors = 0;

  instr_fetch dut (
    .clk(clk), .reset(reset), .pc(pc), .next_instr(next_instr), .flush(flush),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] memf(input logic [10:0] a);
    return {5'h0, a} ^ 16'hA5A5;
  endfunction

  // PC counter model
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           pc <= '0;
    else if (flush)      pc <= tgt;
    else if (next_instr) pc <= pc + 11'd1;
  end

  // Synchronous memory model, 1-cycle latency
  always_ff @(posedge clk) begin
    if (imem_en) imem_rdata <= memf(imem_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h @%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string tag, input logic [10:0] epc);
    chk({tag, "_vld"}, 32'(instr_valid), 32'd1);
    chk({tag, "_pc"},  32'(instr_pc), 32'(epc));
    chk({tag, "_ins"}, 32'(instr), 32'(memf(epc)));
  endtask

  // Hold reset 3 cycles, release, and check the first fetch.
  // Returns in the cycle the first instruction becomes valid.
  task automatic do_reset(input logic rdy);
    reset = 1'b1;
    flush = 1'b0;
    instr_ready = rdy;
    tgt = '0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst_en",  32'(imem_en), 32'd0);
      chk("rst_nx",  32'(next_instr), 32'd0);
      chk("rst_vld", 32'(instr_valid), 32'd0);
    end
    chk("rst_ipc",   32'(instr_pc), 32'd0);
    chk("rst_ins",   32'(instr), 32'd0);
    chk("rst_cnt",   32'(dut.fifo_count), 32'd0);
    reset = 1'b0;
    #1;
    chk("c0_en",   32'(imem_en), 32'd1);
    chk("c0_addr", 32'(imem_addr), 32'd0);
    chk("c0_vld",  32'(instr_valid), 32'd0);
    cyc();
    chk("c1_addr", 32'(imem_addr), 32'd1);
    chk("c1_vld",  32'(instr_valid), 32'd0);
    cyc();
    chk_head("c2", 11'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; instr_ready = 1'b0; tgt = '0;

    // Reset + backpressure
    do_reset(1'b0);
    chk("bp_nx0", 32'(next_instr), 32'd0);
    cyc();
    chk_head("bp3", 11'd0);
    chk("bp_cnt", 32'(dut.fifo_count), 32'd2);
    chk("bp_nx",  32'(next_instr), 32'd0);
    cyc();
    chk_head("bp4", 11'd0);
    instr_ready = 1'b1;
    #1;
    chk("bp_rel_en", 32'(imem_en), 32'd1);
    cyc();
    chk_head("bp5", 11'd1);
    cyc();
    chk_head("bp6", 11'd2);

    // Streaming from pc=0
    do_reset(1'b1);
    for (int i = 0; i < 9; i++) begin
      chk_head("strm", 11'(i));
      cyc();
    end

    // Flush at pc=5, target 2043, then wrap
    do_reset(1'b1);
    cyc();
    chk_head("f3", 11'd1);
    cyc();
    chk_head("f4", 11'd2);
    cyc();
    chk_head("f5", 11'd3);
    chk("f5_addr", 32'(imem_addr), 32'd5);
    flush = 1'b1; tgt = 11'd2043;
    #1;
    chk("fl_vld", 32'(instr_valid), 32'd0);
    chk("fl_nx",  32'(next_instr), 32'd0);
    cyc();
    flush = 1'b0;
    #1;
    chk("fl1_cnt",  32'(dut.fifo_count), 32'd0);
    chk("fl1_vld",  32'(instr_valid), 32'd0);
    chk("fl1_addr", 32'(imem_addr), 32'd2043);
    chk("fl1_en",   32'(imem_en), 32'd1);
    cyc();
    chk("fl2_vld",  32'(instr_valid), 32'd0);
    cyc();
    for (int i = 0; i < 6; i++) begin
      chk_head("wrap", 11'(2043 + i));
      cyc();
    end

    // Two back-to-back flush cycles
    flush = 1'b1; tgt = 11'd100;
    #1;
    chk("bb0_vld", 32'(instr_valid), 32'd0);
    cyc();
    tgt = 11'd200;
    #1;
    chk("bb1_vld", 32'(instr_valid), 32'd0);
    chk("bb1_cnt", 32'(dut.fifo_count), 32'd0);
    chk("bb1_nx",  32'(next_instr), 32'd0);
    cyc();
    flush = 1'b0;
    #1;
    chk("bb2_cnt",  32'(dut.fifo_count), 32'd0);
    chk("bb2_vld",  32'(instr_valid), 32'd0);
    chk("bb2_addr", 32'(imem_addr), 32'd200);
    cyc();
    chk("bb3_vld",  32'(instr_valid), 32'd0);
    cyc();
    chk_head("bb4", 11'd200);
    cyc();
    chk_head("bb5", 11'd201);

    // Fill under backpressure, then async reset between edges
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
    chk("ar_cnt", 32'(dut.fifo_count), 32'd2);
    chk_head("ar_hold", 11'd201);
    #3;
    reset = 1'b1;
    #1;
    chk("ar_vld", 32'(instr_valid), 32'd0);
    chk("ar_en",  32'(imem_en), 32'd0);
    chk("ar_nx",  32'(next_instr), 32'd0);
    chk("ar_cnt0", 32'(dut.fifo_count), 32'd0);
    do_reset(1'b1);
    cyc();
    chk_head("ar_r3", 11'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
